// File: rtl/pop_sort_driver.sv
// -----------------------------------------------------------------------------
// pop_sort_driver
//
// Initiator and reader for the population sorter. One distance per individual
// arrives over a valid/ready stream and is stored by arrival order. Once the
// whole population is loaded, the distance vector is presented to the sorter
// and a one-cycle start pulse is issued. The sorted index list is captured on
// the sorter's done pulse and then streamed out in rank order, best first.
//
// Optional feature macro: SORT_DRIVER_EMIT_DIST_EN
//   When defined, the output port idx_dist carries the distance of the
//   individual currently on idx_data (all-ones for an out-of-range index).
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   dist_valid     fitness stream valid
//   dist_data      distance of individual k (k = arrival order)
//   dist_ready     accepting distances (high only while loading)
//   sorter_dist    flattened distance vector, individual k at [k*DIST_W +: DIST_W]
//   sorter_start   one-cycle start pulse to the sorter
//   sorter_done    one-cycle done pulse from the sorter
//   sorter_sorted  flattened sorted indices, rank r at [r*IDX_W +: IDX_W]
//   idx_valid      output stream valid
//   idx_data       individual index at the current rank
//   idx_rank       current rank, 0 = smallest distance
//   idx_last       high together with rank EMIT_COUNT-1
//   idx_ready      downstream accepts
//   busy           high in every state except LOAD
//   idx_dist       (optional) distance of idx_data, registered with it
// -----------------------------------------------------------------------------
module pop_sort_driver #(
  parameter int POP_SIZE   = 50,
  parameter int DIST_W     = 12,
  parameter int IDX_W      = 6,
  parameter int EMIT_COUNT = 50
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        dist_valid,
  input  logic [DIST_W-1:0]           dist_data,
  output logic                        dist_ready,
  output logic [POP_SIZE*DIST_W-1:0]  sorter_dist,
  output logic                        sorter_start,
  input  logic                        sorter_done,
  input  logic [POP_SIZE*IDX_W-1:0]   sorter_sorted,
  output logic                        idx_valid,
  output logic [IDX_W-1:0]            idx_data,
  output logic [IDX_W-1:0]            idx_rank,
  output logic                        idx_last,
  input  logic                        idx_ready,
  output logic                        busy
`ifdef SORT_DRIVER_EMIT_DIST_EN
  ,
  output logic [DIST_W-1:0]           idx_dist
`endif
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LOAD_LAST = IDX_W'(POP_SIZE - 1);
  localparam logic [IDX_W-1:0] EMIT_LAST = IDX_W'(EMIT_COUNT - 1);

  state_t                      state;
  logic [IDX_W-1:0]            load_cnt;
  logic [IDX_W-1:0]            rank_cnt;
  logic [IDX_W-1:0]            rank_next;
  logic [POP_SIZE*DIST_W-1:0]  dist_buf;
  logic [POP_SIZE*IDX_W-1:0]   rank_buf;

  // The distance buffer is only written while loading, so the sorter sees a
  // stable vector from the start pulse until the last rank has been emitted.
  assign sorter_dist = dist_buf;

  assign rank_next = rank_cnt + IDX_W'(1);

  // Select rank r from a flattened index bus. Written as a compare-and-select
  // loop so every slice is a constant range.
  function automatic logic [IDX_W-1:0] rank_at(
    input logic [POP_SIZE*IDX_W-1:0] bus,
    input logic [IDX_W-1:0]          r
  );
    logic [IDX_W-1:0] v;
    v = '0;
    for (int k = 0; k < POP_SIZE; k++) begin
      if (r == IDX_W'(k)) v = bus[k*IDX_W +: IDX_W];
    end
    return v;
  endfunction

`ifdef SORT_DRIVER_EMIT_DIST_EN
  // Distance of individual idx; indices beyond the population read all-ones
  // because the sorter is allowed to hand back any IDX_W-bit value.
  function automatic logic [DIST_W-1:0] dist_at(input logic [IDX_W-1:0] idx);
    logic [DIST_W-1:0] v;
    v = '1;
    for (int k = 0; k < POP_SIZE; k++) begin
      if (idx == IDX_W'(k)) v = dist_buf[k*DIST_W +: DIST_W];
    end
    return v;
  endfunction
`endif

  // NOTE: every register here is assigned with <= so that all flops update
  // together on the edge; a blocking = would let later statements see the
  // new value mid-block and break the registered timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LOAD;
      load_cnt     <= '0;
      rank_cnt     <= '0;
      // NOTE: both buffers are cleared on reset on purpose: a reset must
      // discard any partial load and captured ranks, and sorter_dist must
      // read all-zero afterwards. This costs a reset net on each bit.
      dist_buf     <= '0;
      rank_buf     <= '0;
      dist_ready   <= 1'b1;
      sorter_start <= 1'b0;
      idx_valid    <= 1'b0;
      idx_last     <= 1'b0;
      idx_data     <= '0;
      idx_rank     <= '0;
      busy         <= 1'b0;
`ifdef SORT_DRIVER_EMIT_DIST_EN
      idx_dist     <= '0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (dist_valid && dist_ready) begin
            for (int k = 0; k < POP_SIZE; k++) begin
              if (load_cnt == IDX_W'(k)) dist_buf[k*DIST_W +: DIST_W] <= dist_data;
            end
            if (load_cnt == LOAD_LAST) begin
              load_cnt     <= '0;
              state        <= S_START;
              sorter_start <= 1'b1;
              dist_ready   <= 1'b0;
              busy         <= 1'b1;
            end else begin
              load_cnt <= load_cnt + IDX_W'(1);
            end
          end
        end

        S_START: begin
          sorter_start <= 1'b0;
          state        <= S_WAIT;
        end

        S_WAIT: begin
          // The sorter only holds its result during the done cycle, so the
          // whole bus is captured here and the first rank is taken straight
          // from the bus rather than from the (not yet written) rank buffer.
          if (sorter_done) begin
            rank_buf  <= sorter_sorted;
            rank_cnt  <= '0;
            state     <= S_EMIT;
            idx_valid <= 1'b1;
            idx_data  <= rank_at(sorter_sorted, '0);
            idx_rank  <= '0;
            idx_last  <= (EMIT_COUNT == 1);
`ifdef SORT_DRIVER_EMIT_DIST_EN
            idx_dist  <= dist_at(rank_at(sorter_sorted, '0));
`endif
          end
        end

        S_EMIT: begin
          // Outputs are only reloaded on a handshake, so they hold while the
          // downstream stalls; with idx_ready held high one rank leaves per
          // cycle.
          if (idx_valid && idx_ready) begin
            if (rank_cnt == EMIT_LAST) begin
              rank_cnt   <= '0;
              state      <= S_LOAD;
              idx_valid  <= 1'b0;
              idx_last   <= 1'b0;
              idx_data   <= '0;
              idx_rank   <= '0;
              dist_ready <= 1'b1;
              busy       <= 1'b0;
`ifdef SORT_DRIVER_EMIT_DIST_EN
              idx_dist   <= '0;
`endif
            end else begin
              rank_cnt <= rank_next;
              idx_data <= rank_at(rank_buf, rank_next);
              idx_rank <= rank_next;
              idx_last <= (rank_next == EMIT_LAST);
`ifdef SORT_DRIVER_EMIT_DIST_EN
              idx_dist <= dist_at(rank_at(rank_buf, rank_next));
`endif
            end
          end
        end

        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule
